// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg: shared LSU FSM states, funct3 and writeback-select encodings
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WB_ALU     = 2'b00;
  localparam logic [1:0] WB_MEM     = 2'b01;
  localparam logic [1:0] WB_PC4     = 2'b10;
  localparam logic [1:0] WB_ALU_ALT = 2'b11;

  // Byte lanes touched by an access of size funct3[1:0] at byte offset off.
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if: MW-stage pipeline, data-memory bus and writeback signals
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface load_store_unit_if;

  logic        memReadMW;
  logic        memWriteMW;
  logic [2:0]  funct3MW;
  logic [31:0] aluResultMW;
  logic [31:0] readData2MW;
  logic [31:0] readAddressMW;
  logic        regWriteMW;
  logic [4:0]  writeAddressMW;
  logic [1:0]  wbSelMW;

  logic        dmemReq;
  logic        dmemWe;
  logic [31:0] dmemAddr;
  logic [3:0]  dmemBe;
  logic [31:0] dmemWdata;
  logic        dmemGnt;
  logic        dmemRvalid;
  logic [31:0] dmemRdata;

  logic        stallMW;
  logic [31:0] writeBackData;
  logic        regWriteWB;
  logic [4:0]  writeAddressWB;
  logic        accessFault;

  modport master (
    input  memReadMW, memWriteMW, funct3MW, aluResultMW, readData2MW,
           readAddressMW, regWriteMW, writeAddressMW, wbSelMW,
           dmemGnt, dmemRvalid, dmemRdata,
    output dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
           stallMW, writeBackData, regWriteWB, writeAddressWB, accessFault
  );

  modport slave (
    output memReadMW, memWriteMW, funct3MW, aluResultMW, readData2MW,
           readAddressMW, regWriteMW, writeAddressMW, wbSelMW,
           dmemGnt, dmemRvalid, dmemRdata,
    input  dmemReq, dmemWe, dmemAddr, dmemBe, dmemWdata,
           stallMW, writeBackData, regWriteWB, writeAddressWB, accessFault
  );

endinterface

`default_nettype wire

// File: rtl/lsu_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align: shifts a read word to its byte offset and sign/zero extends
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'd0, shifted[7:0]};
      F3_HU:   data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit: MW-stage data-memory access FSM with writeback selection
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit
  import riscv_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  load_store_unit_if.master  bus
);

  lsu_state_e  state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [31:0] load_data;
  logic        legal, aligned, access, fault, req;
  logic [1:0]  off;

  assign off = bus.aluResultMW[1:0];

  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    case (bus.funct3MW)
      F3_B:        begin legal = 1'b1;          aligned = 1'b1;          end
      F3_H:        begin legal = 1'b1;          aligned = ~off[0];       end
      F3_W:        begin legal = 1'b1;          aligned = (off == 2'b00); end
      F3_BU:       begin legal = bus.memReadMW; aligned = 1'b1;          end
      F3_HU:       begin legal = bus.memReadMW; aligned = ~off[0];       end
      default:     begin legal = 1'b0;          aligned = 1'b0;          end
    endcase
    access = (bus.memReadMW ^ bus.memWriteMW) & legal & aligned;
    fault  = (bus.memReadMW | bus.memWriteMW) & ~access;
  end

  lsu_load_align u_align (
    .rdata_i  (bus.dmemRdata),
    .offset_i (off),
    .funct3_i (bus.funct3MW),
    .data_o   (load_data)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req = access;
        if (access) state_d = bus.dmemGnt ? ST_WAIT : ST_REQ;
      end
      ST_REQ: begin
        req = 1'b1;
        if (bus.dmemGnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Stores also finish on rvalid; the captured word is simply unused.
        if (bus.dmemRvalid) begin
          data_d  = load_data;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.dmemReq   = req & reset;
  assign bus.dmemWe    = bus.memWriteMW;
  assign bus.dmemAddr  = {bus.aluResultMW[31:2], 2'b00};
  assign bus.dmemBe    = byte_enable(bus.funct3MW, off);

  always_comb begin
    case (bus.funct3MW[1:0])
      2'b00:   bus.dmemWdata = {4{bus.readData2MW[7:0]}};
      2'b01:   bus.dmemWdata = {2{bus.readData2MW[15:0]}};
      default: bus.dmemWdata = bus.readData2MW;
    endcase
  end

  always_comb begin
    case (bus.wbSelMW)
      WB_MEM:            bus.writeBackData = data_q;
      WB_PC4:            bus.writeBackData = bus.readAddressMW + 32'd4;
      WB_ALU, WB_ALU_ALT: bus.writeBackData = bus.aluResultMW;
      default:           bus.writeBackData = bus.aluResultMW;
    endcase
  end

  assign bus.stallMW        = access & (state_q != ST_DONE) & reset;
  assign bus.accessFault    = fault & reset;
  assign bus.regWriteWB     = bus.regWriteMW & ~bus.stallMW & ~fault
                              & (bus.writeAddressMW != 5'd0) & reset;
  assign bus.writeAddressWB = bus.writeAddressMW;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit: directed vectors with a queue-based writeback/bus scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;

  typedef struct {
    logic [31:0] data;
    logic        rw;
    logic [4:0]  wa;
    logic        flt;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic        be_chk;
    logic [31:0] wdata;
  } mem_t;

  logic clock;
  logic reset;
  logic instr_valid;
  int   vectors;
  int   errors;
  wb_t  wb_q[$];
  mem_t mem_q[$];

  load_store_unit_if bus ();

  load_store_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.memReadMW      = 1'b0;
    bus.memWriteMW     = 1'b0;
    bus.funct3MW       = 3'b000;
    bus.aluResultMW    = 32'd0;
    bus.readData2MW    = 32'd0;
    bus.readAddressMW  = 32'd0;
    bus.regWriteMW     = 1'b0;
    bus.writeAddressMW = 5'd0;
    bus.wbSelMW        = 2'b00;
    bus.dmemGnt        = 1'b0;
    bus.dmemRvalid     = 1'b0;
  endtask

  // Monitor: pops expectations whenever the DUT retires an instruction or a bus request is granted.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset && instr_valid && !bus.stallMW) begin
        if (wb_q.size() == 0) begin
          chk("wb_unexpected", 32'd1, 32'd0);
        end else begin
          wb_t w;
          w = wb_q.pop_front();
          chk("wb_data",  bus.writeBackData, w.data);
          chk("wb_rw",    {31'd0, bus.regWriteWB}, {31'd0, w.rw});
          chk("wb_addr",  {27'd0, bus.writeAddressWB}, {27'd0, w.wa});
          chk("wb_fault", {31'd0, bus.accessFault}, {31'd0, w.flt});
        end
      end
      if (reset && bus.dmemReq && bus.dmemGnt) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", 32'd1, 32'd0);
        end else begin
          mem_t m;
          m = mem_q.pop_front();
          chk("mem_addr", bus.dmemAddr, m.addr);
          chk("mem_we",   {31'd0, bus.dmemWe}, {31'd0, m.we});
          if (m.be_chk) chk("mem_be", {28'd0, bus.dmemBe}, {28'd0, m.be});
          if (m.we)     chk("mem_wdata", bus.dmemWdata, m.wdata);
        end
      end
    end
  end

  // Issue one MW instruction and play the memory side until it retires.
  task automatic run(
    input logic rd, input logic wr, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc,
    input logic rw, input logic [4:0] wa, input logic [1:0] sel,
    input logic [31:0] rdata, input int gdly,
    input logic [31:0] exp_wb, input logic exp_rw, input logic exp_flt,
    input logic [31:0] exp_maddr, input logic [3:0] exp_be, input logic be_chk,
    input logic [31:0] exp_wd, input int exp_stall, input int exp_req);
    wb_t  w;
    mem_t m;
    int   n_req, n_stall;
    logic pend, g, rv, done;
    w.data = exp_wb; w.rw = exp_rw; w.wa = wa; w.flt = exp_flt;
    wb_q.push_back(w);
    if (!exp_flt && (rd || wr)) begin
      m.addr = exp_maddr; m.we = wr; m.be = exp_be; m.be_chk = be_chk; m.wdata = exp_wd;
      mem_q.push_back(m);
    end
    bus.memReadMW      = rd;
    bus.memWriteMW     = wr;
    bus.funct3MW       = f3;
    bus.aluResultMW    = addr;
    bus.readData2MW    = wdata;
    bus.readAddressMW  = pc;
    bus.regWriteMW     = rw;
    bus.writeAddressMW = wa;
    bus.wbSelMW        = sel;
    bus.dmemRdata      = rdata;
    instr_valid        = 1'b1;
    n_req = 0; n_stall = 0; pend = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clock);
      if (!bus.stallMW) done = 1'b1;
      else n_stall++;
      rv   = pend;
      pend = 1'b0;
      g    = 1'b0;
      if (bus.dmemReq) begin
        n_req++;
        if (n_req > gdly) begin
          g    = 1'b1;
          pend = 1'b1;
        end
      end
      #1;
      bus.dmemGnt    = g;
      bus.dmemRvalid = rv;
    end
    if (!done) chk("retire_timeout", 32'd0, 32'd1);
    if (exp_stall >= 0) chk("stall_cycles", n_stall, exp_stall);
    if (exp_req >= 0)   chk("req_cycles", n_req, exp_req);
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    errors      = 0;
    instr_valid = 1'b0;
    reset       = 1'b0;
    idle_inputs();
    bus.dmemRdata = 32'd0;
    // Misaligned LW held during reset: every control output must stay low.
    bus.memReadMW = 1'b1; bus.funct3MW = 3'b010; bus.aluResultMW = 32'h101;
    bus.regWriteMW = 1'b1; bus.writeAddressMW = 5'd3;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req",   {31'd0, bus.dmemReq},     32'd0);
    chk("rst_stall", {31'd0, bus.stallMW},     32'd0);
    chk("rst_rw",    {31'd0, bus.regWriteWB},  32'd0);
    chk("rst_fault", {31'd0, bus.accessFault}, 32'd0);
    @(posedge clock);
    #1;
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;

    // rd wr f3 addr wdata pc rw wa sel rdata gdly | wb rw flt maddr be bechk wd stall req
    run(1,0,3'b010,32'h100,32'h0,32'h0,1,5'd5,2'b01,32'hDEADBEEF,0, 32'hDEADBEEF,1,0,32'h100,4'hF,0,32'h0,2,1);
    run(1,0,3'b000,32'h103,32'h0,32'h0,1,5'd6,2'b01,32'h80FFFFFF,0, 32'hFFFFFF80,1,0,32'h100,4'h8,0,32'h0,2,1);
    run(1,0,3'b100,32'h103,32'h0,32'h0,1,5'd6,2'b01,32'h80FFFFFF,0, 32'h00000080,1,0,32'h100,4'h8,0,32'h0,2,1);
    run(1,0,3'b000,32'h101,32'h0,32'h0,1,5'd8,2'b01,32'h00007F00,0, 32'h0000007F,1,0,32'h100,4'h2,0,32'h0,2,1);
    run(1,0,3'b001,32'h102,32'h0,32'h0,1,5'd7,2'b01,32'h80011234,1, 32'hFFFF8001,1,0,32'h100,4'hC,0,32'h0,3,2);
    run(1,0,3'b101,32'h102,32'h0,32'h0,1,5'd7,2'b01,32'h80011234,0, 32'h00008001,1,0,32'h100,4'hC,0,32'h0,2,1);
    run(0,1,3'b001,32'h202,32'h1234ABCD,32'h0,0,5'd0,2'b00,32'h0,3, 32'h00000202,0,0,32'h200,4'hC,1,32'hABCDABCD,5,4);
    run(0,1,3'b000,32'h001,32'h000000A5,32'h0,0,5'd0,2'b00,32'h0,0, 32'h00000001,0,0,32'h000,4'h2,1,32'hA5A5A5A5,2,1);
    run(0,1,3'b010,32'h010,32'hCAFEF00D,32'h0,0,5'd0,2'b00,32'h0,2, 32'h00000010,0,0,32'h010,4'hF,1,32'hCAFEF00D,4,3);
    // Faults: misaligned, illegal store size, both strobes, misaligned halves, illegal load size.
    run(1,0,3'b010,32'h101,32'h0,32'h0,1,5'd5,2'b00,32'h0,0, 32'h00000101,0,1,32'h0,4'h0,0,32'h0,0,0);
    run(0,1,3'b100,32'h010,32'h0,32'h0,1,5'd5,2'b00,32'h0,0, 32'h00000010,0,1,32'h0,4'h0,0,32'h0,0,0);
    run(1,1,3'b010,32'h100,32'h0,32'h0,1,5'd5,2'b00,32'h0,0, 32'h00000100,0,1,32'h0,4'h0,0,32'h0,0,0);
    run(1,0,3'b001,32'h101,32'h0,32'h0,1,5'd5,2'b00,32'h0,0, 32'h00000101,0,1,32'h0,4'h0,0,32'h0,0,0);
    run(1,0,3'b101,32'h103,32'h0,32'h0,1,5'd5,2'b00,32'h0,0, 32'h00000103,0,1,32'h0,4'h0,0,32'h0,0,0);
    run(1,0,3'b011,32'h100,32'h0,32'h0,1,5'd5,2'b00,32'h0,0, 32'h00000100,0,1,32'h0,4'h0,0,32'h0,0,0);
    // Non-memory writebacks: PC+4 wrap, x0 suppression, plain ALU.
    run(0,0,3'b000,32'h0,32'h0,32'hFFFFFFFC,1,5'd7,2'b10,32'h0,0, 32'h00000000,1,0,32'h0,4'h0,0,32'h0,0,0);
    run(0,0,3'b000,32'h12345678,32'h0,32'h0,1,5'd0,2'b11,32'h0,0, 32'h12345678,0,0,32'h0,4'h0,0,32'h0,0,0);
    run(0,0,3'b000,32'h0000A5A5,32'h0,32'h0,1,5'd31,2'b00,32'h0,0, 32'h0000A5A5,1,0,32'h0,4'h0,0,32'h0,0,0);
    run(1,0,3'b010,32'h008,32'h0,32'h0,1,5'd0,2'b01,32'h0BADF00D,0, 32'h0BADF00D,0,0,32'h008,4'hF,0,32'h0,2,1);

    // Reset asserted while the FSM waits for rvalid.
    begin
      mem_t m;
      m.addr = 32'h300; m.we = 1'b0; m.be = 4'h0; m.be_chk = 1'b0; m.wdata = 32'h0;
      mem_q.push_back(m);
    end
    bus.memReadMW = 1'b1; bus.funct3MW = 3'b010; bus.aluResultMW = 32'h300;
    bus.regWriteMW = 1'b1; bus.writeAddressMW = 5'd9; bus.wbSelMW = 2'b01;
    bus.dmemRdata = 32'h55555555;
    @(negedge clock);
    #1 bus.dmemGnt = 1'b1;
    @(posedge clock);
    #1;
    bus.dmemGnt = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_stall", {31'd0, bus.stallMW},    32'd0);
    chk("midrst_req",   {31'd0, bus.dmemReq},    32'd0);
    chk("midrst_rw",    {31'd0, bus.regWriteWB}, 32'd0);
    @(posedge clock);
    #1;
    idle_inputs();
    reset          = 1'b1;
    bus.dmemRvalid = 1'b1;
    bus.dmemRdata  = 32'h11111111;
    @(negedge clock);
    chk("post_rst_stall", {31'd0, bus.stallMW}, 32'd0);
    chk("post_rst_req",   {31'd0, bus.dmemReq}, 32'd0);
    @(posedge clock);
    #1 bus.dmemRvalid = 1'b0;
    // Captured data must be the reset value: the stray rvalid was ignored.
    run(0,0,3'b000,32'h0,32'h0,32'h0,1,5'd9,2'b01,32'h0,0, 32'h00000000,1,0,32'h0,4'h0,0,32'h0,0,0);
    run(1,0,3'b010,32'h104,32'h0,32'h0,1,5'd10,2'b01,32'h01020304,0, 32'h01020304,1,0,32'h104,4'hF,0,32'h0,2,1);

    repeat (2) @(posedge clock);
    chk("wb_queue_empty",  wb_q.size(),  32'd0);
    chk("mem_queue_empty", mem_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have: clock  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-low reset.
REQ-003 SHALL have: memReadMW / memWriteMW  in  1 each  load / store in the MW stage.
REQ-004 SHALL have: funct3MW  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-005 SHALL have: aluResultMW  in  32  effective address.
REQ-006 SHALL have: readData2MW  in  32  store data.
REQ-007 SHALL have: readAddressMW  in  32  PC of the MW instruction.
REQ-008 SHALL have: regWriteMW  in  1, writeAddressMW  in  5, wbSelMW  in  2  (00 ALU, 01 MEM, 10 PC+4, 11 ALU).
REQ-009 SHALL have: dmemReq, dmemWe  out  1; dmemAddr  out  32; dmemBe  out  4; dmemWdata  out  32.
REQ-010 SHALL have: dmemGnt, dmemRvalid  in  1; dmemRdata  in  32.
REQ-011 SHALL have: stallMW  out  1  hold request to the EX/MW pipeline register.
REQ-012 SHALL have: writeBackData  out  32; regWriteWB  out  1; writeAddressWB  out  5; accessFault  out  1.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-014 access = memReadMW XOR memWriteMW, legal funct3, aligned; fault = (memReadMW|memWriteMW) and not access.
REQ-015 Alignment: H needs addr[0]=0, W needs addr[1:0]=00; store funct3 >010, load funct3 011/110/111, or read and write both high SHALL be fault.
REQ-016 IDLE: dmemReq = access; gnt -> WAIT, else -> REQ.
REQ-017 REQ: dmemReq held high with stable addr/be/wdata/we; gnt -> WAIT.
REQ-018 WAIT: dmemReq low; rvalid -> capture dmemRdata, go DONE; dmemRvalid SHALL be ignored in all other states.
REQ-019 DONE: one cycle, unconditional -> IDLE.
REQ-020 stallMW = access and state != DONE; minimum access latency SHALL be 3 cycles (IDLE+gnt, WAIT+rvalid, DONE).
REQ-021 dmemAddr = {aluResultMW[31:2],2'b00}; dmemWe = memWriteMW.
REQ-022 dmemBe: B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111; dmemWdata: byte replicated x4, half replicated x2, word as is.
REQ-023 Load data SHALL be rdata >> 8*addr[1:0], then sign- (B/H) or zero- (BU/HU) extended to 32 bits.
REQ-024 writeBackData: wbSel 01 -> aligned load data (captured register), 10 -> readAddressMW+4 (mod 2^32), else aluResultMW.
REQ-025 regWriteWB = regWriteMW & !stallMW & !fault & (writeAddressMW != 0); writeAddressWB = writeAddressMW.
REQ-026 accessFault = fault, combinational; fault SHALL issue no request and no stall.
REQ-027 Stores SHALL complete via the same rvalid acknowledge as loads.

Reset
REQ-028 reset low at an edge SHALL force state IDLE and captured data 0, including mid-access (REQ/WAIT).
REQ-029 While reset low, dmemReq, stallMW, regWriteWB, accessFault SHALL be 0; an rvalid after reset SHALL be ignored.

Structure
REQ-030 Shared package riscv_pkg SHALL hold the FSM state enum, funct3 encodings and wbSel encodings.
REQ-031 Load extraction/extension SHALL be sub-module lsu_load_align (combinational).

Verification
REQ-032 LW addr 0x100, gnt same cycle, rvalid next, rdata 0xDEADBEEF -> stall 2 cycles, DONE writeBackData 0xDEADBEEF, regWriteWB=1.
REQ-033 LB addr 0x103, rdata 0x80FFFFFF -> dmemBe don't-care for load, writeBackData 0xFFFFFF80; LBU -> 0x00000080.
REQ-034 SH addr 0x202, data 0x1234ABCD, gnt delayed 3 cycles -> dmemReq held 4 cycles, dmemBe 1100, dmemWdata 0xABCDABCD, regWriteWB=0.
REQ-035 LW addr 0x101 -> accessFault=1, dmemReq=0, stallMW=0, regWriteWB=0.
REQ-036 reset low during WAIT, then rvalid -> state IDLE, no writeback, stallMW=0.
REQ-037 wbSel 10, PC 0xFFFFFFFC, no access -> writeBackData 0x00000000, no stall.
